// File: rtl/vga_scan_driver.sv
// VGA raster generator with a 1-clk registered output stage, so the colour and
// the sync pins reach the monitor aligned to the same pixel.
module vga_scan_driver #(
  parameter int clk_mhz    = 50,
  parameter int pixel_mhz  = 25,
  parameter int h_display  = 640,
  parameter int h_front    = 16,
  parameter int h_sync     = 96,
  parameter int h_back     = 48,
  parameter int v_display  = 480,
  parameter int v_front    = 10,
  parameter int v_sync     = 2,
  parameter int v_back     = 33,
  parameter bit hs_act_low = 1'b1,
  parameter bit vs_act_low = 1'b1,
  parameter int w_x        = 10,
  parameter int w_y        = 10,
  parameter int w_red      = 4,
  parameter int w_green    = 4,
  parameter int w_blue     = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pixel_en,
  output logic [w_x-1:0]     x,
  output logic [w_y-1:0]     y,
  output logic               display_on,
  output logic               frame_start,
  input  logic [w_red-1:0]   red_in,
  input  logic [w_green-1:0] green_in,
  input  logic [w_blue-1:0]  blue_in,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [w_red-1:0]   vga_r,
  output logic [w_green-1:0] vga_g,
  output logic [w_blue-1:0]  vga_b
);

  localparam int ratio   = clk_mhz / pixel_mhz;
  localparam int h_total = h_display + h_front + h_sync + h_back;
  localparam int v_total = v_display + v_front + v_sync + v_back;
  localparam int hw      = $clog2(h_total);
  localparam int vw      = $clog2(v_total);

  localparam logic [hw-1:0] h_last   = hw'(h_total - 1);
  localparam logic [hw-1:0] h_disp   = hw'(h_display);
  localparam logic [hw-1:0] hs_first = hw'(h_display + h_front);
  localparam logic [hw-1:0] hs_last  = hw'(h_display + h_front + h_sync - 1);
  localparam logic [vw-1:0] v_last   = vw'(v_total - 1);
  localparam logic [vw-1:0] v_disp   = vw'(v_display);
  localparam logic [vw-1:0] vs_first = vw'(v_display + v_front);
  localparam logic [vw-1:0] vs_last  = vw'(v_display + v_front + v_sync - 1);

  generate
    if ((clk_mhz % pixel_mhz) != 0 || clk_mhz < pixel_mhz) begin : g_bad_ratio
      $error("vga_scan_driver: clk_mhz must be a whole multiple of pixel_mhz");
    end
  endgenerate

  // Pixel-rate strobe: fires on the last clk of each pixel period.
  generate
    if (ratio == 1) begin : g_no_div
      assign pixel_en = 1'b1;
    end else begin : g_div
      localparam int dw = $clog2(ratio);
      localparam logic [dw-1:0] div_last = dw'(ratio - 1);
      logic [dw-1:0] div;

      always_ff @(posedge clk) begin
        if (rst)                 div <= '0;
        else if (div == div_last) div <= '0;
        else                     div <= div + dw'(1);
      end

      assign pixel_en = (div == div_last);
    end
  endgenerate

  logic [hw-1:0] hcnt;
  logic [vw-1:0] vcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pixel_en) begin
      if (hcnt == h_last) begin
        hcnt <= '0;
        vcnt <= (vcnt == v_last) ? '0 : vcnt + vw'(1);
      end else begin
        hcnt <= hcnt + hw'(1);
      end
    end
  end

  logic hs_act;
  logic vs_act;

  always_comb begin
    display_on  = (hcnt < h_disp) && (vcnt < v_disp);
    x           = display_on ? w_x'(hcnt) : '0;
    y           = display_on ? w_y'(vcnt) : '0;
    frame_start = pixel_en && (hcnt == '0) && (vcnt == '0);
    hs_act      = (hcnt >= hs_first) && (hcnt <= hs_last);
    vs_act      = (vcnt >= vs_first) && (vcnt <= vs_last);
  end

  // Inactive sync level equals the act_low flag itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs <= hs_act_low;
      vga_vs <= vs_act_low;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= hs_act ^ hs_act_low;
      vga_vs <= vs_act ^ vs_act_low;
      vga_r  <= display_on ? red_in   : '0;
      vga_g  <= display_on ? green_in : '0;
      vga_b  <= display_on ? blue_in  : '0;
    end
  end

endmodule
